// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer: state
// encodings and the bit-counter width helper.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } piso_state_t;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int piso_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking the bits left after the one currently on
// the serial output; holds at zero instead of wrapping.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = piso_cnt_w(WIDTH)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Load,
  input  logic             i_En,
  input  logic [CNT_W-1:0] i_Load_Val,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Zero
);

  logic [CNT_W-1:0] r_Count;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Count <= '0;
    end else if (i_Load) begin
      r_Count <= i_Load_Val;
    end else if (i_En && (r_Count != '0)) begin
      r_Count <= r_Count - CNT_W'(1);
    end
  end

  assign o_Count = r_Count;
  assign o_Zero  = (r_Count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the delay-line serial input.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [WIDTH-1:0] i_Data,
  input  logic             i_Load_DV,
  output logic             o_Ready,
  output logic             o_Serial,
  output logic             o_Serial_DV,
  output logic             o_Last,
  output logic             o_Busy
);

  localparam int CNT_W = piso_cnt_w(WIDTH);
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  piso_state_t      r_State;
  logic [WIDTH-1:0] r_Shift;
  logic             r_Serial;
  logic             r_Serial_DV;
  logic             r_Last;
  logic             r_Busy;
`ifdef PISO_PARITY_EN
  logic             r_Parity;
`endif

  logic             w_Accept;
  logic             w_Advance;
  logic             w_Cnt_Zero;
  logic             w_Cnt_One;
  logic [CNT_W-1:0] w_Count;
  logic             w_First_Bit;
  logic             w_Next_Bit;

  // Ready depends only on state/counter so i_Load_DV never reaches o_Ready.
`ifdef PISO_PARITY_EN
  assign o_Ready = (r_State == ST_IDLE) || (r_State == ST_PARITY);
`else
  assign o_Ready = (r_State == ST_IDLE) || ((r_State == ST_SHIFT) && w_Cnt_Zero);
`endif

  assign w_Accept    = i_Load_DV && o_Ready;
  assign w_Advance   = (r_State == ST_SHIFT) && !w_Cnt_Zero;
  assign w_Cnt_One   = (w_Count == CNT_W'(1));
  assign w_First_Bit = MSB_FIRST ? i_Data[WIDTH-1] : i_Data[0];
  assign w_Next_Bit  = MSB_FIRST ? r_Shift[WIDTH-2] : r_Shift[1];

  piso_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Load     (w_Accept),
    .i_En       (w_Advance),
    .i_Load_Val (CNT_W'(WIDTH - 1)),
    .o_Count    (w_Count),
    .o_Zero     (w_Cnt_Zero)
  );

  // Word storage carries no reset; r_State gates whether it is ever used.
  always_ff @(posedge i_Clk) begin
    if (w_Accept) begin
      r_Shift <= i_Data;
    end else if (w_Advance) begin
      r_Shift <= MSB_FIRST ? (r_Shift << 1) : (r_Shift >> 1);
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge i_Clk) begin
    if (w_Accept) begin
      r_Parity <= ^i_Data;
    end
  end
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State     <= ST_IDLE;
      r_Serial    <= IDLE_LEVEL;
      r_Serial_DV <= 1'b0;
      r_Last      <= 1'b0;
      r_Busy      <= 1'b0;
    end else if (w_Accept) begin
      r_State     <= ST_SHIFT;
      r_Serial    <= w_First_Bit;
      r_Serial_DV <= 1'b1;
      r_Last      <= 1'b0;
      r_Busy      <= 1'b1;
    end else begin
      case (r_State)
        ST_SHIFT: begin
          if (!w_Cnt_Zero) begin
            r_Serial <= w_Next_Bit;
            r_Last   <= w_Cnt_One && !PAR_EN;
          end else begin
`ifdef PISO_PARITY_EN
            r_State  <= ST_PARITY;
            r_Serial <= r_Parity;
            r_Last   <= 1'b1;
`else
            r_State     <= ST_IDLE;
            r_Serial    <= IDLE_LEVEL;
            r_Serial_DV <= 1'b0;
            r_Last      <= 1'b0;
            r_Busy      <= 1'b0;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        ST_PARITY: begin
          r_State     <= ST_IDLE;
          r_Serial    <= IDLE_LEVEL;
          r_Serial_DV <= 1'b0;
          r_Last      <= 1'b0;
          r_Busy      <= 1'b0;
        end
`endif
        default: begin
          r_State     <= ST_IDLE;
          r_Serial    <= IDLE_LEVEL;
          r_Serial_DV <= 1'b0;
          r_Last      <= 1'b0;
          r_Busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_Serial    = r_Serial;
  assign o_Serial_DV = r_Serial_DV;
  assign o_Last      = r_Last;
  assign o_Busy      = r_Busy;

endmodule
